mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 52 +++++
 rtl/mem_stage_load_extend.sv | 39 +++
 rtl/mem_stage.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- shared definitions for the load/store memory stage.
//   * RISC-V funct3 size/sign encodings for loads and stores
//   * FSM state type used by mem_stage
//   * helpers that derive lane count / lane-offset width from XLEN and
//     classify a funct3/address pair as legal and aligned
package mem_stage_pkg;

    // funct3 encodings (bit 2 = unsigned load, bits 1:0 = log2 of access bytes)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Number of byte lanes on the data bus.
    function automatic int lane_count(input int xlen);
        return xlen / 8;
    endfunction

    // Width of the byte offset inside one bus word.
    function automatic int off_width(input int xlen);
        return $clog2(xlen / 8);
    endfunction

    // D and WU only exist on a 64-bit datapath; 111 is never legal.
    function automatic logic funct3_legal(input logic [2:0] f3, input int xlen);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
            F3_D, F3_WU:                    return (xlen == 64);
            default:                        return 1'b0;
        endcase
    endfunction

    // Natural alignment check on the three low address bits.
    function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return |lo[1:0];
            2'b11:   return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// mem_stage_load_extend -- combinational load-data formatter.
// Selects the accessed bytes out of a full-lane bus word and sign- or
// zero-extends them to XLEN according to funct3.
// Ports:
//   rdata  [XLEN-1:0]  full-lane read data from the bus
//   funct3 [2:0]       access size/sign code of the load
//   offset [2:0]       byte offset of the access inside the bus word
//                      (upper bit is always 0 on a 32-bit datapath)
//   data   [XLEN-1:0]  extended load result
module mem_stage_load_extend
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [2:0]      offset,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        // Move the first accessed byte down to lane 0.
        shifted = rdata >> {offset, 3'b000};
        data    = '0;
        case (funct3)
            F3_B:    data = XLEN'($signed(shifted[7:0]));
            F3_H:    data = XLEN'($signed(shifted[15:0]));
            F3_W:    data = XLEN'($signed(shifted[31:0]));
            F3_BU:   data = XLEN'(shifted[7:0]);
            F3_HU:   data = XLEN'(shifted[15:0]);
            F3_WU:   data = XLEN'(shifted[31:0]);
            F3_D:    data = shifted;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- single-outstanding load/store unit between a CPU pipeline
// and a simple request/acknowledge memory bus.
// A request is accepted in IDLE, checked for legality/alignment, then either
// answered immediately with an error or issued on the bus until mem_ack or
// until TIMEOUT bus cycles elapse. The response is a one-cycle pulse.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              CPU handshake (ready only in IDLE)
//   req_we, req_funct3, req_addr,    access type, size/sign code, byte
//   req_wdata                        address, store data
//   resp_valid, resp_rdata, resp_err one-cycle response, held data/error
//   mem_req, mem_we, mem_addr,       bus request, lane-aligned address,
//   mem_be, mem_wdata                byte enables, lane-replicated data
//   mem_ack, mem_rdata               bus completion and full-lane read data
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 resp_err,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [XLEN/8-1:0]    mem_be,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic                 mem_ack,
    input  logic [XLEN-1:0]      mem_rdata
);

    localparam int LANES = lane_count(XLEN);
    localparam int OFF_W = off_width(XLEN);

    state_e              state_reg, state_next;
    logic [7:0]          cnt_reg, cnt_next;
    logic [XLEN-1:0]     resp_rdata_reg, resp_rdata_next;
    logic                resp_err_reg, resp_err_next;

    // Access attributes captured at acceptance.
    logic [2:0]          funct3_reg;
    logic [2:0]          off_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [LANES-1:0]    mem_be_reg;
    logic [XLEN-1:0]     mem_wdata_reg;

    logic                accept;
    logic                req_ok;
    logic                timeout_hit;
    logic [2:0]          req_off;
    logic [3:0]          off4;
    logic [3:0]          sz_bytes;
    logic [ADDR_W-1:0]   addr_aligned;
    logic [LANES-1:0]    be_calc;
    logic [XLEN-1:0]     wdata_rep;
    logic [XLEN-1:0]     load_data;

    assign accept       = req_valid && (state_reg == ST_IDLE);
    assign req_ok       = funct3_legal(req_funct3, XLEN) && !misaligned(req_funct3, req_addr[2:0]);
    // Counter reaches TIMEOUT at the end of this cycle if no ack arrives.
    assign timeout_hit  = (cnt_reg == 8'(TIMEOUT - 1));
    assign req_off      = 3'(req_addr[OFF_W-1:0]);
    assign off4         = 4'(req_off);
    assign sz_bytes     = 4'd1 << req_funct3[1:0];
    assign addr_aligned = req_addr & ~ADDR_W'(LANES - 1);

    // Per-lane byte enable and store-data replication. Each lane takes the
    // store byte at (lane mod access_size), so the data lines up with the
    // enabled lanes whatever the offset.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign be_calc[gi] = (4'(gi) >= off4) && (4'(gi) < off4 + sz_bytes);
            assign wdata_rep[gi*8 +: 8] =
                (req_funct3[1:0] == 2'b00) ? req_wdata[7:0] :
                (req_funct3[1:0] == 2'b01) ? req_wdata[(gi % 2)*8 +: 8] :
                (req_funct3[1:0] == 2'b10) ? req_wdata[(gi % 4)*8 +: 8] :
                                             req_wdata[gi*8 +: 8];
        end
    endgenerate

    mem_stage_load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .rdata  (mem_rdata),
        .funct3 (funct3_reg),
        .offset (off_reg),
        .data   (load_data)
    );

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        resp_rdata_next = resp_rdata_reg;
        resp_err_next   = resp_err_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (req_valid) begin
                    if (req_ok) begin
                        state_next = ST_BUS;
                    end else begin
                        state_next      = ST_RESP;
                        resp_err_next   = 1'b1;
                        resp_rdata_next = '0;
                    end
                end
            end
            ST_BUS: begin
                // An ack arriving in the expiry cycle still completes normally.
                if (mem_ack) begin
                    state_next      = ST_RESP;
                    resp_err_next   = 1'b0;
                    resp_rdata_next = we_reg ? '0 : load_data;
                end else if (timeout_hit) begin
                    state_next      = ST_RESP;
                    resp_err_next   = 1'b1;
                    resp_rdata_next = '0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            resp_rdata_reg <= resp_rdata_next;
            resp_err_reg   <= resp_err_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_reg    <= '0;
            off_reg       <= '0;
            we_reg        <= 1'b0;
            mem_addr_reg  <= '0;
            mem_be_reg    <= '0;
            mem_wdata_reg <= '0;
        end else if (accept) begin
            funct3_reg    <= req_funct3;
            off_reg       <= req_off;
            we_reg        <= req_we;
            mem_addr_reg  <= addr_aligned;
            mem_be_reg    <= be_calc;
            mem_wdata_reg <= wdata_rep;
        end
    end

    assign req_ready  = (state_reg == ST_IDLE);
    assign resp_valid = (state_reg == ST_RESP);
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
    assign mem_req    = (state_reg == ST_BUS);
    assign mem_we     = we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_be     = mem_be_reg;
    assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- randomized self-checking bench for mem_stage.
// Two instances share stimulus: a 32-bit and a 64-bit datapath, both with a
// short timeout. Only the selected instance sees req_valid; observed outputs
// are muxed by 'sel' and compared against a byte-level reference model.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid32 = 1'b0, valid64 = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;

    logic        r32_ready, r32_rvalid, r32_err, m32_req, m32_we;
    logic [31:0] r32_rdata, m32_addr, m32_wdata;
    logic [3:0]  m32_be;
    logic        r64_ready, r64_rvalid, r64_err, m64_req, m64_we;
    logic [63:0] r64_rdata, m64_wdata;
    logic [31:0] m64_addr;
    logic [7:0]  m64_be;

    bit          sel = 1'b0;
    logic [63:0] o_ready, o_rvalid, o_rdata, o_err, o_req, o_we, o_addr, o_be, o_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut32 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid32), .req_ready(r32_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .resp_valid(r32_rvalid), .resp_rdata(r32_rdata),
        .resp_err(r32_err), .mem_req(m32_req), .mem_we(m32_we), .mem_addr(m32_addr),
        .mem_be(m32_be), .mem_wdata(m32_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata[31:0])
    );

    mem_stage #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TO)) dut64 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid64), .req_ready(r64_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(r64_rvalid), .resp_rdata(r64_rdata),
        .resp_err(r64_err), .mem_req(m64_req), .mem_we(m64_we), .mem_addr(m64_addr),
        .mem_be(m64_be), .mem_wdata(m64_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always_comb begin
        o_ready  = sel ? 64'(r64_ready)  : 64'(r32_ready);
        o_rvalid = sel ? 64'(r64_rvalid) : 64'(r32_rvalid);
        o_rdata  = sel ? r64_rdata       : 64'(r32_rdata);
        o_err    = sel ? 64'(r64_err)    : 64'(r32_err);
        o_req    = sel ? 64'(m64_req)    : 64'(m32_req);
        o_we     = sel ? 64'(m64_we)     : 64'(m32_we);
        o_addr   = sel ? 64'(m64_addr)   : 64'(m32_addr);
        o_be     = sel ? 64'(m64_be)     : 64'(m32_be);
        o_wdata  = sel ? m64_wdata       : 64'(m32_wdata);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: what the bus and the response should look like, derived
    // byte by byte from the access size, offset and sign rules.
    function automatic void ref_model(input int xlen, input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [63:0] wd, input logic [63:0] md,
                                      output bit bad, output logic [31:0] e_addr,
                                      output logic [7:0] e_be, output logic [63:0] e_wd,
                                      output logic [63:0] e_rd);
        int lanes, size, off;
        logic [63:0] v;
        lanes  = xlen / 8;
        size   = 1 << f3[1:0];
        bad    = (f3 == 3'b111) || ((f3 == 3'b011 || f3 == 3'b110) && xlen == 32) ||
                 ((addr % size) != 0);
        off    = int'(addr % lanes);
        e_addr = addr - 32'(off);
        e_be   = '0;
        e_wd   = '0;
        for (int i = 0; i < lanes; i++) begin
            if (i >= off && i < off + size) e_be[i] = 1'b1;
            e_wd[i*8 +: 8] = wd[(i % size)*8 +: 8];
        end
        v = '0;
        for (int i = 0; i < size; i++)
            if (off + i < 8) v[i*8 +: 8] = md[(off + i)*8 +: 8];
        if (!f3[2] && size * 8 < xlen && v[size*8-1])
            for (int b = size * 8; b < xlen; b++) v[b] = 1'b1;
        e_rd = v;
    endfunction

    // One complete access. ack_at = BUS cycle (1..TO) in which mem_ack is
    // raised, 0 = never. Called at #1 after a rising edge with DUT in IDLE.
    task automatic run_access(input bit s, input bit we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [63:0] wd,
                              input logic [63:0] md, input int ack_at, input string tag);
        bit          bad, done;
        logic [31:0] e_addr;
        logic [7:0]  e_be;
        logic [63:0] e_wd, e_rd, exp_r, exp_e;
        if (!s) begin
            wd[63:32] = '0;
            md[63:32] = '0;
        end
        ref_model(s ? 64 : 32, f3, addr, wd, md, bad, e_addr, e_be, e_wd, e_rd);
        sel        = s;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        mem_rdata  = md;
        if (s) valid64 = 1'b1; else valid32 = 1'b1;
        #1 check_eq({tag, "_ready"}, o_ready, 64'd1);
        @(posedge clk); #1;
        valid32 = 1'b0;
        valid64 = 1'b0;
        exp_r = '0;
        exp_e = 64'd1;
        if (bad) begin
            check_eq({tag, "_err_noreq"}, o_req, 64'd0);
            check_eq({tag, "_err_rvalid"}, o_rvalid, 64'd1);
            check_eq({tag, "_err_err"}, o_err, 64'd1);
            check_eq({tag, "_err_rdata"}, o_rdata, 64'd0);
        end else begin
            done = 1'b0;
            for (int n = 1; n <= TO && !done; n++) begin
                check_eq({tag, "_memreq"}, o_req, 64'd1);
                check_eq({tag, "_busy_rvalid"}, o_rvalid, 64'd0);
                if (n == 1) begin
                    check_eq({tag, "_addr"}, o_addr, 64'(e_addr));
                    check_eq({tag, "_be"}, o_be, 64'(e_be));
                    check_eq({tag, "_we"}, o_we, 64'(we));
                    if (we) check_eq({tag, "_wdata"}, o_wdata, e_wd);
                end
                mem_ack = (n == ack_at);
                @(posedge clk); #1;
                mem_ack = 1'b0;
                if (n == ack_at || n == TO) begin
                    if (n == ack_at) begin
                        exp_e = 64'd0;
                        exp_r = we ? 64'd0 : e_rd;
                    end
                    check_eq({tag, "_resp_rvalid"}, o_rvalid, 64'd1);
                    check_eq({tag, "_resp_err"}, o_err, exp_e);
                    check_eq({tag, "_resp_rdata"}, o_rdata, exp_r);
                    check_eq({tag, "_resp_noreq"}, o_req, 64'd0);
                    done = 1'b1;
                end
            end
        end
        // Bus data changes after the response must not disturb held results.
        mem_rdata = {$urandom, $urandom};
        @(posedge clk); #1;
        check_eq({tag, "_idle_rvalid"}, o_rvalid, 64'd0);
        check_eq({tag, "_idle_ready"}, o_ready, 64'd1);
        check_eq({tag, "_hold_rdata"}, o_rdata, exp_r);
        check_eq({tag, "_hold_err"}, o_err, exp_e);
        $display("txn %s xlen=%0d we=%0d f3=%0d addr=0x%0h ack_at=%0d -> err=%0d rdata=0x%0h",
                 tag, s ? 64 : 32, we, f3, addr, ack_at, o_err[0], o_rdata);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int          sz;

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            check_eq("rst_ready", o_ready, 64'd1);
            check_eq("rst_memreq", o_req, 64'd0);
            check_eq("rst_memwe", o_we, 64'd0);
            check_eq("rst_membe", o_be, 64'd0);
            check_eq("rst_rvalid", o_rvalid, 64'd0);
            check_eq("rst_err", o_err, 64'd0);
            check_eq("rst_rdata", o_rdata, 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_access(1'b0, 1'b0, 3'b000, 32'h103, 64'd0, 64'h80FF_FF00, 1, "lb_0x103");
        check_eq("lb_0x103_value", o_rdata, 64'hFFFF_FF80);
        run_access(1'b0, 1'b1, 3'b001, 32'h102, 64'h0000_ABCD, 64'd0, 1, "sh_0x102");
        run_access(1'b0, 1'b0, 3'b010, 32'h101, 64'd0, 64'hDEAD_BEEF, 1, "lw_misal");
        check_eq("lw_misal_value", o_err, 64'd1);
        run_access(1'b0, 1'b0, 3'b010, 32'h40, 64'd0, 64'h1234_5678, 0, "lw_timeout");
        run_access(1'b0, 1'b0, 3'b010, 32'h40, 64'd0, 64'h1234_5678, TO, "lw_ack_last");
        check_eq("lw_ack_last_value", o_rdata, 64'h1234_5678);
        run_access(1'b0, 1'b0, 3'b011, 32'h8, 64'd0, 64'd0, 1, "ld_on_rv32");
        run_access(1'b1, 1'b0, 3'b011, 32'h8, 64'd0, 64'h8765_4321_0FED_CBA9, 1, "ld_rv64");
        check_eq("ld_rv64_value", o_rdata, 64'h8765_4321_0FED_CBA9);
        run_access(1'b1, 1'b0, 3'b110, 32'h14, 64'd0, 64'h8000_0000_0000_0000, 2, "lwu_rv64");

        // Reset pulsed while the 32-bit instance waits on the bus.
        sel = 1'b0;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
        valid32 = 1'b1;
        @(posedge clk); #1;
        valid32 = 1'b0;
        @(posedge clk); #1;
        check_eq("rstbus_memreq_before", o_req, 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rstbus_memreq_now", o_req, 64'd0);
        check_eq("rstbus_rvalid", o_rvalid, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_ack = (i == 0);
            @(negedge clk);
            check_eq("rstbus_no_resp", o_rvalid, 64'd0);
            check_eq("rstbus_idle_ready", o_ready, 64'd1);
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        run_access(1'b0, 1'b0, 3'b100, 32'h201, 64'd0, 64'h0000_9A00, 1, "after_rst");

        // Randomized accesses on both datapaths.
        for (int t = 0; t < 80; t++) begin
            f3 = 3'($urandom_range(0, 7));
            sz = 1 << f3[1:0];
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
            run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3, a,
                       {$urandom, $urandom}, {$urandom, $urandom},
                       int'($urandom_range(0, TO)), $sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
